// File: rtl/maxnet_pkg.sv
// Shared widths and FSM encoding for the MAXNET iteration controller.
package maxnet_pkg;

   localparam int unsigned FP_WIDTH = 32;
   localparam int unsigned N_PU     = 4;
   localparam int unsigned NZ_W     = 3;
   localparam int unsigned IDX_W    = 2;
   localparam int unsigned ITER_W   = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_EVAL = 2'd2,
      ST_DONE = 2'd3
   } state_t;

endpackage

// File: rtl/maxnet_iter_ctrl_if.sv
// PU-side bus: activation vector out to the four PUs, ReLU results and zero flags back.
interface maxnet_iter_ctrl_if;
   import maxnet_pkg::*;

   logic [FP_WIDTH-1:0] x_0, x_1, x_2, x_3;
   logic [FP_WIDTH-1:0] pu_out_0, pu_out_1, pu_out_2, pu_out_3;
   logic                zero_0, zero_1, zero_2, zero_3;

   modport master (
      output x_0, x_1, x_2, x_3,
      input  pu_out_0, pu_out_1, pu_out_2, pu_out_3,
      input  zero_0, zero_1, zero_2, zero_3
   );

   modport slave (
      input  x_0, x_1, x_2, x_3,
      output pu_out_0, pu_out_1, pu_out_2, pu_out_3,
      output zero_0, zero_1, zero_2, zero_3
   );

endinterface

// File: rtl/nonzero_encoder.sv
// Counts PUs with a nonzero output and reports the lowest such index.
module nonzero_encoder
   import maxnet_pkg::*;
(
   input  logic [N_PU-1:0]  zero,
   output logic [NZ_W-1:0]  nz,
   output logic [IDX_W-1:0] win_idx
);

   // Scan high-to-low so the last hit is the lowest nonzero index.
   always_comb begin
      nz      = '0;
      win_idx = '0;
      for (int i = N_PU - 1; i >= 0; i--) begin
         if (!zero[i]) begin
            nz      = nz + NZ_W'(1);
            win_idx = IDX_W'(i);
         end
      end
   end

endmodule

// File: rtl/maxnet_iter_ctrl.sv
// MAXNET competition controller: loads a vector, iterates it through the PUs
// until a single nonzero survives, everything dies, or the iteration limit hits.
module maxnet_iter_ctrl
   import maxnet_pkg::*;
#(
   parameter int unsigned PU_LATENCY = 2,
   parameter int unsigned MAX_ITER   = 255
)(
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [FP_WIDTH-1:0] x_in_0,
   input  logic [FP_WIDTH-1:0] x_in_1,
   input  logic [FP_WIDTH-1:0] x_in_2,
   input  logic [FP_WIDTH-1:0] x_in_3,
   maxnet_iter_ctrl_if.master  pu,
   output logic                busy,
   output logic                done,
   output logic                no_winner,
   output logic [IDX_W-1:0]    winner,
   output logic [FP_WIDTH-1:0] max_value,
   output logic [ITER_W-1:0]   iter_count
);

   localparam int unsigned WAIT_W = (PU_LATENCY > 1) ? $clog2(PU_LATENCY) : 1;

   state_t              state_q, state_d;
   logic [WAIT_W-1:0]   wait_q, wait_d;
   logic [FP_WIDTH-1:0] x_q [N_PU];
   logic [FP_WIDTH-1:0] x_d [N_PU];
   logic [FP_WIDTH-1:0] pu_vec [N_PU];
   logic [N_PU-1:0]     zero_vec;
   logic [NZ_W-1:0]     nz;
   logic [IDX_W-1:0]    win_idx;
   logic                busy_d, done_d, no_winner_d;
   logic [IDX_W-1:0]    winner_d;
   logic [FP_WIDTH-1:0] max_value_d;
   logic [ITER_W-1:0]   iter_d;
   logic                at_limit;

   assign pu_vec[0] = pu.pu_out_0;
   assign pu_vec[1] = pu.pu_out_1;
   assign pu_vec[2] = pu.pu_out_2;
   assign pu_vec[3] = pu.pu_out_3;
   assign zero_vec  = {pu.zero_3, pu.zero_2, pu.zero_1, pu.zero_0};

   // X registers feed the PUs directly, no extra stage.
   assign pu.x_0 = x_q[0];
   assign pu.x_1 = x_q[1];
   assign pu.x_2 = x_q[2];
   assign pu.x_3 = x_q[3];

   nonzero_encoder u_nz_enc (
      .zero    (zero_vec),
      .nz      (nz),
      .win_idx (win_idx)
   );

   assign at_limit = ({1'b0, iter_count} + 9'd1) == 9'(MAX_ITER);

   always_comb begin
      state_d     = state_q;
      wait_d      = wait_q;
      x_d         = x_q;
      done_d      = done;
      no_winner_d = no_winner;
      winner_d    = winner;
      max_value_d = max_value;
      iter_d      = iter_count;
      unique case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               x_d         = '{x_in_0, x_in_1, x_in_2, x_in_3};
               iter_d      = '0;
               done_d      = 1'b0;
               no_winner_d = 1'b0;
               winner_d    = '0;
               max_value_d = '0;
               wait_d      = '0;
               state_d     = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (wait_q == WAIT_W'(PU_LATENCY - 1)) state_d = ST_EVAL;
            else                                   wait_d  = wait_q + WAIT_W'(1);
         end
         ST_EVAL: begin
            x_d    = pu_vec;
            iter_d = (iter_count == '1) ? iter_count : iter_count + ITER_W'(1);
            wait_d = '0;
            // A sole survivor wins even on the final permitted iteration.
            if (nz == NZ_W'(1)) begin
               state_d     = ST_DONE;
               done_d      = 1'b1;
               winner_d    = win_idx;
               max_value_d = pu_vec[win_idx];
            end else if (nz == '0 || at_limit) begin
               state_d     = ST_DONE;
               done_d      = 1'b1;
               no_winner_d = 1'b1;
               winner_d    = '0;
               max_value_d = '0;
            end else begin
               state_d     = ST_WAIT;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      busy_d = (state_d == ST_WAIT) || (state_d == ST_EVAL);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         wait_q     <= '0;
         x_q        <= '{default: '0};
         busy       <= 1'b0;
         done       <= 1'b0;
         no_winner  <= 1'b0;
         winner     <= '0;
         max_value  <= '0;
         iter_count <= '0;
      end else begin
         state_q    <= state_d;
         wait_q     <= wait_d;
         x_q        <= x_d;
         busy       <= busy_d;
         done       <= done_d;
         no_winner  <= no_winner_d;
         winner     <= winner_d;
         max_value  <= max_value_d;
         iter_count <= iter_d;
      end
   end

endmodule
